// File: rtl/ex_mem_stage_buf_if.sv
// EX->MEM stage bus: EX-side entry inputs plus MEM-side registered outputs.
// The stage uses the slave modport; the EX/MEM environment uses master.
interface ex_mem_stage_buf_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 7
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CTRL_W-1:0]     in_ctrl;
  logic [XLEN-1:0]       in_alu_result;
  logic [XLEN-1:0]       in_store_data;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_zero;
  logic                  in_branch_taken;
  logic                  in_jump_taken;
  logic [XLEN-1:0]       in_target;
  logic [XLEN-1:0]       in_link_addr;

  logic                  out_valid;
  logic                  out_ready;
  logic [CTRL_W-1:0]     out_ctrl;
  logic [XLEN-1:0]       out_alu_result;
  logic [XLEN-1:0]       out_store_data;
  logic [XLEN-1:0]       out_target;
  logic [XLEN-1:0]       out_link_addr;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_zero;
  logic                  out_taken;

  modport slave (
    input  in_valid, in_ctrl, in_alu_result, in_store_data, in_rd, in_zero,
           in_branch_taken, in_jump_taken, in_target, in_link_addr, out_ready,
    output in_ready, out_valid, out_ctrl, out_alu_result, out_store_data,
           out_target, out_link_addr, out_rd, out_zero, out_taken
  );

  modport master (
    output in_valid, in_ctrl, in_alu_result, in_store_data, in_rd, in_zero,
           in_branch_taken, in_jump_taken, in_target, in_link_addr, out_ready,
    input  in_ready, out_valid, out_ctrl, out_alu_result, out_store_data,
           out_target, out_link_addr, out_rd, out_zero, out_taken
  );
endinterface

// File: rtl/ex_mem_stage_buf.sv
// EX->MEM pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// Optional EX_MEM_PERF_CNT_EN adds saturating stall_cnt / bubble_cnt outputs.
module ex_mem_stage_buf #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  ex_mem_stage_buf_if.slave   bus
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         bubble_cnt
`endif
);

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  zero;
    logic                  taken;
    logic [XLEN-1:0]       target;
    logic [XLEN-1:0]       link_addr;
  } entry_t;

  // Encoding doubles as {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   in_ready_q, in_ready_d;
  logic   main_valid;
  logic   in_xfer;
  logic   out_xfer;

  // A bubble keeps the last data fields but must present no control.
  function automatic entry_t to_bubble(entry_t e);
    entry_t b;
    b       = e;
    b.ctrl  = '0;
    b.taken = 1'b0;
    return b;
  endfunction

  always_comb begin
    in_entry.ctrl       = bus.in_ctrl;
    in_entry.alu_result = bus.in_alu_result;
    in_entry.store_data = bus.in_store_data;
    in_entry.rd         = bus.in_rd;
    in_entry.zero       = bus.in_zero;
    in_entry.taken      = bus.in_branch_taken | bus.in_jump_taken;
    in_entry.target     = bus.in_target;
    in_entry.link_addr  = bus.in_link_addr;
  end

  assign main_valid = (state_q != ST_EMPTY);
  assign in_xfer    = bus.in_valid & in_ready_q;
  assign out_xfer   = main_valid & bus.out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = in_entry;
          state_d = ST_HALF;
        end
      end
      ST_HALF: begin
        if (in_xfer && out_xfer) begin
          main_d = in_entry;
        end else if (in_xfer) begin
          skid_d  = in_entry;
          state_d = ST_FULL;
        end else if (out_xfer) begin
          main_d  = to_bubble(main_q);
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_HALF;
        end
      end
      default: begin
        main_d  = to_bubble(main_q);
        state_d = ST_EMPTY;
      end
    endcase

    // Flush drops any incoming entry; an out transfer this cycle has still completed.
    if (flush) begin
      main_d  = to_bubble(main_q);
      state_d = ST_EMPTY;
    end

    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      in_ready_q <= in_ready_d;
    end
  end

  // NOTE: skid payload is not reset; its contents are only observed once the FULL state marks it valid.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = main_valid;
  assign bus.out_ctrl       = main_q.ctrl;
  assign bus.out_alu_result = main_q.alu_result;
  assign bus.out_store_data = main_q.store_data;
  assign bus.out_target     = main_q.target;
  assign bus.out_link_addr  = main_q.link_addr;
  assign bus.out_rd         = main_q.rd;
  assign bus.out_zero       = main_q.zero;
  assign bus.out_taken      = main_q.taken;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!main_valid && bus.out_ready && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Self-checking bench for ex_mem_stage_buf: directed steps plus randomized traffic
// compared every cycle against a queue-based FIFO reference model.
module tb_ex_mem_stage_buf;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        zero;
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
  } ent_t;

  logic clk;
  logic reset;
  logic flush;
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  ent_t        exp_q[$];
  ent_t        last_shown;
  logic [31:0] m_stall;
  logic [31:0] m_bubble;

  ex_mem_stage_buf_if #(.XLEN(32), .REG_ADDR_W(5), .CTRL_W(7)) bus ();

  ex_mem_stage_buf #(.XLEN(32), .REG_ADDR_W(5), .CTRL_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus)
`ifdef EX_MEM_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

`ifndef EX_MEM_PERF_CNT_EN
  assign stall_cnt  = 32'd0;
  assign bubble_cnt = 32'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    assert_cnt++;
    assert (obs === exp_v) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic ent_t cur_in();
    ent_t e;
    e.ctrl   = bus.in_ctrl;
    e.alu    = bus.in_alu_result;
    e.sd     = bus.in_store_data;
    e.rd     = bus.in_rd;
    e.zero   = bus.in_zero;
    e.taken  = bus.in_branch_taken | bus.in_jump_taken;
    e.target = bus.in_target;
    e.link   = bus.in_link_addr;
    return e;
  endfunction

  // Reference: a capacity-2 FIFO; EX may push only when it held fewer than 2 entries.
  task automatic model_edge();
    bit   had_valid;
    bit   could_accept;
    ent_t dropped;
    if (!reset) begin
      exp_q.delete();
      last_shown = '0;
      m_stall    = 32'd0;
      m_bubble   = 32'd0;
    end else begin
      had_valid    = (exp_q.size() > 0);
      could_accept = (exp_q.size() < 2);
      if (had_valid && !bus.out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (!had_valid && bus.out_ready && m_bubble != 32'hFFFF_FFFF) m_bubble++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (had_valid && bus.out_ready) dropped = exp_q.pop_front();
        if (bus.in_valid && could_accept) exp_q.push_back(cur_in());
      end
      if (exp_q.size() > 0) last_shown = exp_q[0];
    end
  endtask

  task automatic compare();
    ent_t e;
    logic v;
    v = (exp_q.size() > 0);
    e = last_shown;
    if (!v) begin
      e.ctrl  = '0;
      e.taken = 1'b0;
    end
    check("out_valid",  64'(bus.out_valid),      64'(v));
    check("in_ready",   64'(bus.in_ready),       64'(exp_q.size() < 2));
    check("out_ctrl",   64'(bus.out_ctrl),       64'(e.ctrl));
    check("out_taken",  64'(bus.out_taken),      64'(e.taken));
    check("out_alu",    64'(bus.out_alu_result), 64'(e.alu));
    check("out_sd",     64'(bus.out_store_data), 64'(e.sd));
    check("out_rd",     64'(bus.out_rd),         64'(e.rd));
    check("out_zero",   64'(bus.out_zero),       64'(e.zero));
    check("out_target", 64'(bus.out_target),     64'(e.target));
    check("out_link",   64'(bus.out_link_addr),  64'(e.link));
`ifdef EX_MEM_PERF_CNT_EN
    check("stall_cnt",  64'(stall_cnt),          64'(m_stall));
    check("bubble_cnt", 64'(bubble_cnt),         64'(m_bubble));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic drive_in(input logic v, input logic [31:0] alu, input logic [6:0] ctrl);
    bus.in_valid        = v;
    bus.in_alu_result   = alu;
    bus.in_ctrl         = ctrl;
    bus.in_store_data   = alu ^ 32'hA5A5_0000;
    bus.in_rd           = alu[4:0];
    bus.in_zero         = alu[0];
    bus.in_branch_taken = 1'b0;
    bus.in_jump_taken   = 1'b0;
    bus.in_target       = 32'd0;
    bus.in_link_addr    = 32'd0;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, 32'd0, 7'd0);
    last_shown = '0;
    m_stall    = 32'd0;
    m_bubble   = 32'd0;

    cycle();
    cycle();
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ready", 64'(bus.in_ready),  64'd1);

    // Single entry, one-cycle latency
    reset = 1'b1;
    bus.out_ready = 1'b1;
    drive_in(1'b1, 32'h0000_0040, 7'b0001001);
    cycle();
    check("t1_valid", 64'(bus.out_valid),      64'd1);
    check("t1_alu",   64'(bus.out_alu_result), 64'h40);
    check("t1_ctrl",  64'(bus.out_ctrl),       64'h09);
    check("t1_ready", 64'(bus.in_ready),       64'd1);
    drive_in(1'b0, 32'd0, 7'd0);
    cycle();

    // Fill to FULL under stall, then drain in order
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h11, 7'b0000001);
    cycle();
    drive_in(1'b1, 32'h22, 7'b0000010);
    cycle();
    drive_in(1'b0, 32'd0, 7'd0);
    check("t2_full_ready", 64'(bus.in_ready),      64'd0);
    check("t2_head_a",     64'(bus.out_alu_result), 64'h11);
    cycle();
    check("t2_stall_hold", 64'(bus.out_alu_result), 64'h11);
    bus.out_ready = 1'b1;
    cycle();
    check("t2_head_b",     64'(bus.out_alu_result), 64'h22);
    check("t2_ready_back", 64'(bus.in_ready),       64'd1);
    cycle();
    check("t2_empty",      64'(bus.out_valid),      64'd0);

    // Flush while FULL drops the concurrent input
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h11, 7'b0001001);
    cycle();
    drive_in(1'b1, 32'h22, 7'b0001001);
    cycle();
    flush = 1'b1;
    drive_in(1'b1, 32'h33, 7'b0001001);
    cycle();
    check("t3_valid", 64'(bus.out_valid), 64'd0);
    check("t3_ctrl",  64'(bus.out_ctrl),  64'd0);
    check("t3_taken", 64'(bus.out_taken), 64'd0);
    check("t3_ready", 64'(bus.in_ready),  64'd1);
    flush = 1'b0;
    drive_in(1'b0, 32'd0, 7'd0);
    bus.out_ready = 1'b1;
    cycle();
    check("t3_no_c", 64'(bus.out_valid), 64'd0);
    cycle();

    // Jump taken fields, then bubble
    drive_in(1'b1, 32'h0, 7'b0011000);
    bus.in_jump_taken = 1'b1;
    bus.in_target     = 32'h0000_1000;
    bus.in_link_addr  = 32'h0000_0204;
    cycle();
    check("t4_taken",  64'(bus.out_taken),     64'd1);
    check("t4_target", 64'(bus.out_target),    64'h1000);
    check("t4_link",   64'(bus.out_link_addr), 64'h204);
    drive_in(1'b0, 32'd0, 7'd0);
    cycle();
    check("t4_bubble_taken", 64'(bus.out_taken), 64'd0);

    // Reset discards a stalled FULL buffer
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h55, 7'b0000001);
    cycle();
    drive_in(1'b1, 32'h66, 7'b0000001);
    cycle();
    drive_in(1'b0, 32'd0, 7'd0);
    for (int i = 0; i < 4; i++) cycle();
`ifdef EX_MEM_PERF_CNT_EN
    check("t5_stall5", 64'(stall_cnt), 64'd5);
`endif
    reset = 1'b0;
    flush = 1'b1;
    drive_in(1'b1, 32'h77, 7'b1111111);
    cycle();
    check("t5_valid", 64'(bus.out_valid),      64'd0);
    check("t5_alu",   64'(bus.out_alu_result), 64'd0);
    check("t5_ready", 64'(bus.in_ready),       64'd1);
`ifdef EX_MEM_PERF_CNT_EN
    check("t5_stall0", 64'(stall_cnt), 64'd0);
`endif
    reset = 1'b1;
    flush = 1'b0;
    drive_in(1'b0, 32'd0, 7'd0);
    cycle();

    // Randomized traffic against the FIFO model
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      r = $urandom();
      bus.in_ctrl         = r[6:0];
      bus.in_rd           = r[11:7];
      bus.in_zero         = r[12];
      bus.in_branch_taken = r[13];
      bus.in_jump_taken   = r[14];
      bus.in_alu_result   = $urandom();
      bus.in_store_data   = $urandom();
      bus.in_target       = $urandom();
      bus.in_link_addr    = $urandom();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
